// File: rtl/tmds_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tmds_pkg: control tokens, disparity counter type and popcount helper      |
// | shared by the TMDS encoder. Rev 1.0                                       |
// +---------------------------------------------------------------------------+
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

  localparam int DISP_CNT_W = 5;
  typedef logic signed [DISP_CNT_W-1:0] disp_cnt_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_channel_encoder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tmds_channel_encoder: one TMDS 8b/10b channel, 3 register stages with its |
// | own running-disparity counter. Monitor taps under TMDS_DISP_MON_EN.       |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tmds_channel_encoder
  import tmds_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              d,
  input  logic                    de,
  input  logic                    c1,
  input  logic                    c0,
`ifdef TMDS_DISP_MON_EN
  output logic signed [CNT_W-1:0] cnt,
  output logic                    disp_viol,
`endif
  output logic [9:0]              q
);

  localparam logic signed [CNT_W-1:0] TWO      = CNT_W'(2);
  localparam logic signed [CNT_W-1:0] DISP_MAX = CNT_W'(8);
  localparam logic signed [CNT_W-1:0] DISP_MIN = CNT_W'(-8);

  // stage 1
  logic [7:0] d1_q, d1_d;
  logic [3:0] n1_1_q, n1_1_d;
  logic       de1_q, de1_d, c1_1_q, c1_1_d, c0_1_q, c0_1_d;
  // stage 2
  logic [8:0] qm2_q, qm2_d;
  logic [3:0] n1_2_q, n1_2_d, n0_2_q, n0_2_d;
  logic       de2_q, de2_d, c1_2_q, c1_2_d, c0_2_q, c0_2_d;
  logic       use_xnor;
  // stage 3
  logic [9:0]              q_q, q_d;
  logic signed [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [CNT_W-1:0] n1_s, n0_s;

  always_comb begin
    d1_d   = d;
    n1_1_d = popcount8(d);
    de1_d  = de;
    c1_1_d = c1;
    c0_1_d = c0;
  end

  always_comb begin
    use_xnor = (n1_1_q > 4'd4) || ((n1_1_q == 4'd4) && !d1_q[0]);
    qm2_d    = '0;
    qm2_d[0] = d1_q[0];
    for (int i = 1; i < 8; i++) begin
      qm2_d[i] = use_xnor ? ~(qm2_d[i-1] ^ d1_q[i]) : (qm2_d[i-1] ^ d1_q[i]);
    end
    qm2_d[8] = ~use_xnor;
    n1_2_d   = popcount8(qm2_d[7:0]);
    n0_2_d   = 4'd8 - n1_2_d;
    de2_d    = de1_q;
    c1_2_d   = c1_1_q;
    c0_2_d   = c0_1_q;
  end

  // N1/N0 are unsigned 0..8; widen by value before signed arithmetic
  assign n1_s = CNT_W'(n1_2_q);
  assign n0_s = CNT_W'(n0_2_q);

  always_comb begin
    q_d   = CTRL_TOKEN_00;
    cnt_d = '0;
    if (!de2_q) begin
      case ({c1_2_q, c0_2_q})
        2'b00:   q_d = CTRL_TOKEN_00;
        2'b01:   q_d = CTRL_TOKEN_01;
        2'b10:   q_d = CTRL_TOKEN_10;
        default: q_d = CTRL_TOKEN_11;
      endcase
    end else if ((cnt_q == '0) || (n1_2_q == n0_2_q)) begin
      q_d   = {~qm2_q[8], qm2_q[8], qm2_q[8] ? qm2_q[7:0] : ~qm2_q[7:0]};
      cnt_d = qm2_q[8] ? (cnt_q + (n1_s - n0_s)) : (cnt_q + (n0_s - n1_s));
    end else if ((!cnt_q[CNT_W-1] && (n1_2_q > n0_2_q)) ||
                 ( cnt_q[CNT_W-1] && (n0_2_q > n1_2_q))) begin
      q_d   = {1'b1, qm2_q[8], ~qm2_q[7:0]};
      cnt_d = cnt_q + (qm2_q[8] ? TWO : '0) + (n0_s - n1_s);
    end else begin
      q_d   = {1'b0, qm2_q[8], qm2_q[7:0]};
      cnt_d = cnt_q - (qm2_q[8] ? '0 : TWO) + (n1_s - n0_s);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d1_q   <= '0;
      n1_1_q <= '0;
      de1_q  <= 1'b0;
      c1_1_q <= 1'b0;
      c0_1_q <= 1'b0;
      qm2_q  <= '0;
      n1_2_q <= '0;
      n0_2_q <= '0;
      de2_q  <= 1'b0;
      c1_2_q <= 1'b0;
      c0_2_q <= 1'b0;
      q_q    <= CTRL_TOKEN_00;
      cnt_q  <= '0;
    end else begin
      d1_q   <= d1_d;
      n1_1_q <= n1_1_d;
      de1_q  <= de1_d;
      c1_1_q <= c1_1_d;
      c0_1_q <= c0_1_d;
      qm2_q  <= qm2_d;
      n1_2_q <= n1_2_d;
      n0_2_q <= n0_2_d;
      de2_q  <= de2_d;
      c1_2_q <= c1_2_d;
      c0_2_q <= c0_2_d;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q = q_q;

`ifdef TMDS_DISP_MON_EN
  logic de3_q, de3_d;

  assign de3_d = de2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      de3_q <= 1'b0;
    end else begin
      de3_q <= de3_d;
    end
  end

  // flags a bad update this cycle; the top level makes it sticky
  always_comb begin
    disp_viol = 1'b0;
    if (de2_q) begin
      disp_viol = (cnt_d > DISP_MAX) || (cnt_d < DISP_MIN) ||
                  (!de3_q && (cnt_q != '0));
    end
  end

  assign cnt = cnt_q;
`endif

endmodule
`default_nettype wire

// File: rtl/tmds_encoder_3ch.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tmds_encoder_3ch: three-channel DVI/TMDS encoder, fixed 3-cycle latency.  |
// | Define TMDS_DISP_MON_EN to add the disp_err / disp_cnt debug outputs.     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tmds_encoder_3ch
  import tmds_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vde,
  input  logic               hsync,
  input  logic               vsync,
  input  logic [3:0]         ctl,
  input  logic [7:0]         red,
  input  logic [7:0]         green,
  input  logic [7:0]         blue,
`ifdef TMDS_DISP_MON_EN
  output logic               disp_err,
  output logic [3*CNT_W-1:0] disp_cnt,
`endif
  output logic [9:0]         r,
  output logic [9:0]         g,
  output logic [9:0]         b,
  output logic               out_vde
);

  generate
    if (LATENCY != 3) begin : g_bad_latency
      $error("tmds_encoder_3ch: LATENCY must be 3");
    end
    if (CNT_W < $bits(disp_cnt_t)) begin : g_bad_cnt_w
      $error("tmds_encoder_3ch: CNT_W too narrow for the disparity range");
    end
  endgenerate

  logic [2:0] vde_pipe_q, vde_pipe_d;

  assign vde_pipe_d = {vde_pipe_q[1:0], vde};

  always_ff @(posedge clk) begin
    if (reset) begin
      vde_pipe_q <= '0;
    end else begin
      vde_pipe_q <= vde_pipe_d;
    end
  end

  assign out_vde = vde_pipe_q[2];

`ifdef TMDS_DISP_MON_EN
  logic signed [CNT_W-1:0] cnt_r, cnt_g, cnt_b;
  logic                    viol_r, viol_g, viol_b;
  logic                    disp_err_q, disp_err_d;
`endif

  // blue carries HSYNC/VSYNC; green and red carry CTL0..CTL3
  tmds_channel_encoder #(.CNT_W(CNT_W)) u_enc_b (
    .clk       (clk),
    .reset     (reset),
    .d         (blue),
    .de        (vde),
    .c1        (vsync),
    .c0        (hsync),
`ifdef TMDS_DISP_MON_EN
    .cnt       (cnt_b),
    .disp_viol (viol_b),
`endif
    .q         (b)
  );

  tmds_channel_encoder #(.CNT_W(CNT_W)) u_enc_g (
    .clk       (clk),
    .reset     (reset),
    .d         (green),
    .de        (vde),
    .c1        (ctl[1]),
    .c0        (ctl[0]),
`ifdef TMDS_DISP_MON_EN
    .cnt       (cnt_g),
    .disp_viol (viol_g),
`endif
    .q         (g)
  );

  tmds_channel_encoder #(.CNT_W(CNT_W)) u_enc_r (
    .clk       (clk),
    .reset     (reset),
    .d         (red),
    .de        (vde),
    .c1        (ctl[3]),
    .c0        (ctl[2]),
`ifdef TMDS_DISP_MON_EN
    .cnt       (cnt_r),
    .disp_viol (viol_r),
`endif
    .q         (r)
  );

`ifdef TMDS_DISP_MON_EN
  assign disp_err_d = disp_err_q | viol_r | viol_g | viol_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_err_q <= 1'b0;
    end else begin
      disp_err_q <= disp_err_d;
    end
  end

  assign disp_err = disp_err_q;
  assign disp_cnt = {cnt_r, cnt_g, cnt_b};
`endif

endmodule
`default_nettype wire
